// File: rtl/mixer_if_nco_if.sv
// mixer_if_nco_if: bundle between the prescalers and the IF NCO (master drives en/pd/rf_edge/osc_edge; slave returns if_cnt/if_valid/ovf/out_sample/out_valid)
interface mixer_if_nco_if #(
  parameter int NCH = 2,
  parameter int CNT_W = 16,
  parameter int OUT_W = 12
);
  logic en;
  logic [NCH-1:0] pd, rf_edge, osc_edge, ovf;
  logic [NCH*CNT_W-1:0] if_cnt;
  logic if_valid, out_valid;
  logic [NCH*OUT_W-1:0] out_sample;
  modport master(output en, pd, rf_edge, osc_edge, input if_cnt, if_valid, ovf, out_sample, out_valid);
  modport slave(input en, pd, rf_edge, osc_edge, output if_cnt, if_valid, ovf, out_sample, out_valid);
endinterface

// File: rtl/mixer_if_nco.sv
// mixer_if_nco: per-channel gated RF/LO edge counter feeding a cosine NCO; ports clk, rst_n (async low), bus (slave: en, pd, rf_edge, osc_edge in; if_cnt, if_valid, ovf, out_sample, out_valid out)
module mixer_if_nco #(
  parameter int NCH = 2,
  parameter int CNT_W = 16,
  parameter int GATE_CYCLES = 100,
  parameter int PHASE_W = 20,
  parameter int OUT_W = 12,
  parameter int DEFAULT_IF = 1
) (
  input logic clk,
  input logic rst_n,
  mixer_if_nco_if.slave bus
);
  localparam int WIN_W = $clog2(GATE_CYCLES);
  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [CNT_W-1:0] DEF = CNT_W'(DEFAULT_IF);
  localparam int AMP = 2 ** (OUT_W - 1) - 1;
  function automatic int cos_tab(int k);
    real x, term, sum;
    x = 3.14159265358979323846 * (2.0 * k + 1.0) / 256.0;
    term = 1.0;
    sum = 1.0;
    for (int n = 1; n <= 14; n++) begin
      term = -term * x * x / ((2.0 * n - 1.0) * (2.0 * n));
      sum = sum + term;
    end
    return $rtoi(real'(AMP) * sum + 0.5);
  endfunction
  logic [OUT_W-2:0] tbl [64];
  for (genvar k = 0; k < 64; k++) begin : g_tbl
    localparam int V = cos_tab(k);
    assign tbl[k] = V[OUT_W-2:0];
  end
  logic [WIN_W-1:0] win_cnt;
  logic close, if_valid_r, out_valid_r;
  assign close = bus.en && win_cnt == WIN_W'(GATE_CYCLES - 1);
  assign bus.if_valid = if_valid_r;
  assign bus.out_valid = out_valid_r;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      win_cnt <= '0;
      if_valid_r <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      if_valid_r <= close;
      out_valid_r <= bus.en;
      if (bus.en) win_cnt <= close ? '0 : win_cnt + WIN_W'(1);
    end
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [CNT_W-1:0] rf_c, osc_c, rf_n, osc_n, ifc;
    logic live, rf_sat, osc_sat, pend, ovf_r;
    logic [PHASE_W-1:0] phase;
    logic [7:0] p8;
    logic [OUT_W-2:0] mag;
    logic signed [OUT_W-1:0] cosv, smp;
    // ovf flags a pulse lost against a full counter, so an exact full-scale count is not an overflow
    always_comb begin
      live = bus.en && !bus.pd[c];
      rf_sat = live && bus.rf_edge[c] && rf_c == CMAX;
      osc_sat = live && bus.osc_edge[c] && osc_c == CMAX;
      rf_n = rf_c + CNT_W'(live && bus.rf_edge[c] && !rf_sat);
      osc_n = osc_c + CNT_W'(live && bus.osc_edge[c] && !osc_sat);
      p8 = phase[PHASE_W-1 -: 8];
      mag = p8[6] ? tbl[~p8[5:0]] : tbl[p8[5:0]];
      cosv = (p8[7] ^ p8[6]) ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
    end
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        rf_c <= '0;
        osc_c <= '0;
        pend <= 1'b0;
        ifc <= DEF;
        ovf_r <= 1'b0;
        phase <= '0;
        smp <= '0;
      end else if (bus.en) begin
        rf_c <= close ? '0 : rf_n;
        osc_c <= close ? '0 : osc_n;
        pend <= !close && (pend || rf_sat || osc_sat);
        if (close) begin
          ifc <= (bus.pd[c] || rf_n <= osc_n) ? DEF : rf_n - osc_n;
          ovf_r <= pend || rf_sat || osc_sat;
        end
        phase <= bus.pd[c] ? '0 : phase + PHASE_W'(ifc);
        smp <= bus.pd[c] ? '0 : cosv;
      end
    assign bus.if_cnt[c*CNT_W +: CNT_W] = ifc;
    assign bus.ovf[c] = ovf_r;
    assign bus.out_sample[c*OUT_W +: OUT_W] = smp;
  end
endmodule

// File: tb/tb_mixer_if_nco.sv
// tb_mixer_if_nco: three configurations (default, CNT_W=4, DEFAULT_IF=4096) driven in lockstep and checked against an arithmetic model
module tb_mixer_if_nco;
  localparam real PI = 3.14159265358979323846;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0;
  logic [1:0] pd = '0, rf = '0, osc = '0;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  mixer_if_nco_if #(.NCH(2), .CNT_W(16), .OUT_W(12)) bus_a();
  mixer_if_nco_if #(.NCH(2), .CNT_W(4), .OUT_W(12)) bus_b();
  mixer_if_nco_if #(.NCH(2), .CNT_W(16), .OUT_W(12)) bus_c();
  assign bus_a.en = en;
  assign bus_a.pd = pd;
  assign bus_a.rf_edge = rf;
  assign bus_a.osc_edge = osc;
  assign bus_b.en = en;
  assign bus_b.pd = pd;
  assign bus_b.rf_edge = rf;
  assign bus_b.osc_edge = osc;
  assign bus_c.en = en;
  assign bus_c.pd = pd;
  assign bus_c.rf_edge = rf;
  assign bus_c.osc_edge = osc;
  mixer_if_nco #(.NCH(2), .CNT_W(16), .GATE_CYCLES(100), .PHASE_W(20), .OUT_W(12), .DEFAULT_IF(1))
    u_a (.clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
  mixer_if_nco #(.NCH(2), .CNT_W(4), .GATE_CYCLES(100), .PHASE_W(20), .OUT_W(12), .DEFAULT_IF(1))
    u_b (.clk(clk), .rst_n(rst_n), .bus(bus_b.slave));
  mixer_if_nco #(.NCH(2), .CNT_W(16), .GATE_CYCLES(100), .PHASE_W(20), .OUT_W(12), .DEFAULT_IF(4096))
    u_c (.clk(clk), .rst_n(rst_n), .bus(bus_c.slave));
  int d_if [3][2], d_smp [3][2];
  logic d_ovf [3][2];
  logic d_ifv [3], d_ov [3];
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      d_if[0][c] = int'(bus_a.if_cnt[c*16 +: 16]);
      d_if[1][c] = int'(bus_b.if_cnt[c*4 +: 4]);
      d_if[2][c] = int'(bus_c.if_cnt[c*16 +: 16]);
      d_smp[0][c] = int'($signed(bus_a.out_sample[c*12 +: 12]));
      d_smp[1][c] = int'($signed(bus_b.out_sample[c*12 +: 12]));
      d_smp[2][c] = int'($signed(bus_c.out_sample[c*12 +: 12]));
      d_ovf[0][c] = bus_a.ovf[c];
      d_ovf[1][c] = bus_b.ovf[c];
      d_ovf[2][c] = bus_c.ovf[c];
    end
    d_ifv[0] = bus_a.if_valid;
    d_ifv[1] = bus_b.if_valid;
    d_ifv[2] = bus_c.if_valid;
    d_ov[0] = bus_a.out_valid;
    d_ov[1] = bus_b.out_valid;
    d_ov[2] = bus_c.out_valid;
  end
  // reference: unbounded pulse tallies per window, clipped to each counter width at close
  int cw [3] = '{16, 4, 16};
  int dflt [3] = '{1, 1, 4096};
  int m_rf [2], m_osc [2], m_win;
  int e_if [3][2] = '{'{1, 1}, '{1, 1}, '{4096, 4096}};
  int e_ph [3][2], e_smp [3][2];
  logic e_ovf [3][2];
  logic e_ifv = 1'b0, e_ov = 1'b0;
  function automatic int ref_cos(int ph);
    real s;
    s = 2047.0 * $cos(2.0 * PI * (real'(ph >> 12) + 0.5) / 256.0);
    return s >= 0.0 ? $rtoi(s + 0.5) : -$rtoi(0.5 - s);
  endfunction
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_win = 0;
      e_ifv = 1'b0;
      e_ov = 1'b0;
      for (int c = 0; c < 2; c++) begin
        m_rf[c] = 0;
        m_osc[c] = 0;
        for (int i = 0; i < 3; i++) begin
          e_if[i][c] = dflt[i];
          e_ovf[i][c] = 1'b0;
          e_ph[i][c] = 0;
          e_smp[i][c] = 0;
        end
      end
    end else if (en) begin
      e_ov = 1'b1;
      for (int c = 0; c < 2; c++) begin
        if (!pd[c]) begin
          m_rf[c] += int'(rf[c]);
          m_osc[c] += int'(osc[c]);
        end
        for (int i = 0; i < 3; i++) begin
          e_smp[i][c] = pd[c] ? 0 : ref_cos(e_ph[i][c]);
          e_ph[i][c] = pd[c] ? 0 : (e_ph[i][c] + e_if[i][c]) % (1 << 20);
        end
      end
      e_ifv = (m_win == 99);
      if (m_win == 99) begin
        for (int c = 0; c < 2; c++) begin
          for (int i = 0; i < 3; i++) begin
            int mx, r, o;
            mx = (1 << cw[i]) - 1;
            r = m_rf[c] > mx ? mx : m_rf[c];
            o = m_osc[c] > mx ? mx : m_osc[c];
            e_if[i][c] = (pd[c] || r <= o) ? dflt[i] : r - o;
            e_ovf[i][c] = m_rf[c] > mx || m_osc[c] > mx;
          end
          m_rf[c] = 0;
          m_osc[c] = 0;
        end
        m_win = 0;
      end else m_win++;
    end else begin
      e_ifv = 1'b0;
      e_ov = 1'b0;
    end
  end
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic apply_reset;
    en = 1'b0;
    pd = '0;
    rf = '0;
    osc = '0;
    @(negedge clk);
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
  endtask
  task automatic run_window(input int r0, input int o0, input int r1, input int o1);
    for (int k = 0; k < 100; k++) begin
      rf = {k < r1, k < r0};
      osc = {k < o1, k < o0};
      tick;
    end
    rf = '0;
    osc = '0;
  endtask
  task automatic test_reset;
    int early;
    en = 1'b1;
    for (int k = 0; k < 37; k++) begin
      pd = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      rf = 2'($urandom);
      osc = 2'($urandom);
      tick;
    end
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      for (int c = 0; c < 2; c++) begin
        total++;
        if (d_if[i][c] !== dflt[i]) begin bad++; $display("FAIL reset_if_cnt u%0d ch%0d got=%0d exp=%0d", i, c, d_if[i][c], dflt[i]); end
        total++;
        if (d_ovf[i][c] !== 1'b0) begin bad++; $display("FAIL reset_ovf u%0d ch%0d got=%b exp=0", i, c, d_ovf[i][c]); end
        total++;
        if (d_smp[i][c] !== 0) begin bad++; $display("FAIL reset_sample u%0d ch%0d got=%0d exp=0", i, c, d_smp[i][c]); end
      end
      total++;
      if (d_ifv[i] !== 1'b0) begin bad++; $display("FAIL reset_if_valid u%0d got=%b exp=0", i, d_ifv[i]); end
      total++;
      if (d_ov[i] !== 1'b0) begin bad++; $display("FAIL reset_out_valid u%0d got=%b exp=0", i, d_ov[i]); end
    end
    tick;
    rst_n = 1'b1;
    pd = '0;
    early = 0;
    for (int k = 0; k < 99; k++) begin
      rf = 2'($urandom);
      osc = 2'($urandom);
      tick;
      if (d_ifv[0] !== 1'b0) early++;
    end
    rf = 2'($urandom);
    osc = 2'($urandom);
    tick;
    total++;
    if (early !== 0) begin bad++; $display("FAIL reset_no_early_valid got=%0d pulses exp=0", early); end
    total++;
    if (d_ifv[0] !== 1'b1) begin bad++; $display("FAIL reset_first_window_valid got=%b exp=1", d_ifv[0]); end
    total++;
    if (d_if[0][0] !== e_if[0][0]) begin bad++; $display("FAIL reset_first_window_cnt got=%0d exp=%0d", d_if[0][0], e_if[0][0]); end
  endtask
  task automatic test_if_measure;
    apply_reset;
    en = 1'b1;
    for (int k = 0; k < 100; k++) begin
      rf = {k < 10, k < 50};
      osc = {k >= 50 && k < 90, k < 30};
      tick;
      if (k == 98) begin
        total++;
        if (d_ifv[0] !== 1'b0) begin bad++; $display("FAIL measure_valid_early got=%b exp=0", d_ifv[0]); end
      end
    end
    rf = '0;
    osc = '0;
    total++;
    if (d_ifv[0] !== 1'b1) begin bad++; $display("FAIL measure_valid_cycle101 got=%b exp=1", d_ifv[0]); end
    total++;
    if (d_if[0][0] !== 20) begin bad++; $display("FAIL measure_ch0 got=%0d exp=20", d_if[0][0]); end
    total++;
    if (d_if[0][1] !== 1) begin bad++; $display("FAIL measure_ch1 got=%0d exp=1", d_if[0][1]); end
    total++;
    if (d_ovf[0][0] !== 1'b0) begin bad++; $display("FAIL measure_ovf got=%b exp=0", d_ovf[0][0]); end
    tick;
    total++;
    if (d_ifv[0] !== 1'b0) begin bad++; $display("FAIL measure_valid_width got=%b exp=0", d_ifv[0]); end
  endtask
  task automatic test_boundary;
    apply_reset;
    en = 1'b1;
    for (int k = 0; k < 100; k++) begin
      rf = {k == 99, 1'b1};
      osc = 2'b01;
      tick;
    end
    rf = '0;
    osc = '0;
    total++;
    if (d_if[2][0] !== 4096) begin bad++; $display("FAIL coincident_default got=%0d exp=4096", d_if[2][0]); end
    total++;
    if (d_if[0][0] !== 1) begin bad++; $display("FAIL coincident_default_a got=%0d exp=1", d_if[0][0]); end
    total++;
    if (d_if[2][1] !== 1) begin bad++; $display("FAIL last_cycle_pulse got=%0d exp=1", d_if[2][1]); end
  endtask
  task automatic test_saturation;
    apply_reset;
    en = 1'b1;
    run_window(20, 0, 5, 0);
    total++;
    if (d_if[1][0] !== 15) begin bad++; $display("FAIL sat_cnt got=%0d exp=15", d_if[1][0]); end
    total++;
    if (d_ovf[1][0] !== 1'b1) begin bad++; $display("FAIL sat_ovf got=%b exp=1", d_ovf[1][0]); end
    total++;
    if (d_if[1][1] !== 5 || d_ovf[1][1] !== 1'b0) begin bad++; $display("FAIL sat_other_ch got=%0d/%b exp=5/0", d_if[1][1], d_ovf[1][1]); end
    total++;
    if (d_if[0][0] !== 20 || d_ovf[0][0] !== 1'b0) begin bad++; $display("FAIL sat_wide_cnt got=%0d/%b exp=20/0", d_if[0][0], d_ovf[0][0]); end
    run_window(3, 0, 0, 0);
    total++;
    if (d_ovf[1][0] !== 1'b0 || d_if[1][0] !== 3) begin bad++; $display("FAIL sat_clear got=%0d/%b exp=3/0", d_if[1][0], d_ovf[1][0]); end
  endtask
  task automatic test_pd_en;
    int cyc, snap_smp [3][2], snap_if [3][2];
    logic bad_frz;
    apply_reset;
    en = 1'b1;
    for (int k = 0; k < 50; k++) begin
      rf = 2'($urandom);
      osc = 2'b00;
      tick;
    end
    pd = 2'b10;
    tick;
    total++;
    if (d_smp[0][1] !== 0 || d_smp[2][1] !== 0) begin bad++; $display("FAIL pd_zero got=%0d/%0d exp=0", d_smp[0][1], d_smp[2][1]); end
    total++;
    if (d_smp[0][0] !== e_smp[0][0]) begin bad++; $display("FAIL pd_ch0_unaffected got=%0d exp=%0d", d_smp[0][0], e_smp[0][0]); end
    pd = 2'b00;
    tick;
    total++;
    if (d_smp[0][1] !== ref_cos(0)) begin bad++; $display("FAIL pu_restart got=%0d exp=%0d", d_smp[0][1], ref_cos(0)); end
    cyc = 52;
    snap_smp = d_smp;
    snap_if = d_if;
    en = 1'b0;
    bad_frz = 1'b0;
    for (int k = 0; k < 7; k++) begin
      rf = 2'($urandom);
      osc = 2'($urandom);
      tick;
      cyc++;
      if (d_smp != snap_smp || d_if != snap_if || d_ov[0] !== 1'b0 || d_ifv[0] !== 1'b0) bad_frz = 1'b1;
    end
    total++;
    if (bad_frz !== 1'b0) begin bad++; $display("FAIL en_freeze got=changed exp=held"); end
    en = 1'b1;
    rf = '0;
    osc = '0;
    for (int k = 0; k < 200 && d_ifv[0] !== 1'b1; k++) begin
      tick;
      cyc++;
    end
    total++;
    if (cyc !== 107) begin bad++; $display("FAIL en_delayed_valid got=%0d exp=107 cycles", cyc); end
  endtask
  task automatic test_nco;
    int s [512];
    int mx, mn, per_bad, sym_bad, t0;
    t0 = ref_cos(0);
    apply_reset;
    en = 1'b1;
    tick;
    total++;
    if (d_smp[2][0] !== t0) begin bad++; $display("FAIL nco_first got=%0d exp=%0d", d_smp[2][0], t0); end
    s[0] = d_smp[2][0];
    for (int n = 1; n < 512; n++) begin
      tick;
      s[n] = d_smp[2][0];
      total++;
      if (s[n] !== ref_cos((n * 4096) % (1 << 20))) begin bad++; $display("FAIL nco_sample n=%0d got=%0d exp=%0d", n, s[n], ref_cos((n * 4096) % (1 << 20))); end
    end
    mx = s[0];
    mn = s[0];
    per_bad = 0;
    sym_bad = 0;
    for (int n = 0; n < 512; n++) begin
      mx = s[n] > mx ? s[n] : mx;
      mn = s[n] < mn ? s[n] : mn;
      if (n < 256 && s[n] != s[n+256]) per_bad++;
      if (n < 384 && s[n] != -s[n+128]) sym_bad++;
    end
    total++;
    if (mx !== t0 || mn !== -t0) begin bad++; $display("FAIL nco_peak got=%0d/%0d exp=%0d/%0d", mx, mn, t0, -t0); end
    total++;
    if (per_bad !== 0) begin bad++; $display("FAIL nco_period got=%0d diffs exp=0", per_bad); end
    total++;
    if (sym_bad !== 0) begin bad++; $display("FAIL nco_symmetry got=%0d diffs exp=0", sym_bad); end
  endtask
  task automatic test_random;
    for (int k = 0; k < 800; k++) begin
      en = $urandom_range(0, 9) != 0;
      if ($urandom_range(0, 49) == 0) pd = 2'($urandom);
      rf = 2'($urandom);
      osc = 2'($urandom);
      tick;
      for (int i = 0; i < 3; i++) begin
        for (int c = 0; c < 2; c++) begin
          total++;
          if (d_if[i][c] !== e_if[i][c]) begin bad++; $display("FAIL rnd_if_cnt k=%0d u%0d ch%0d got=%0d exp=%0d", k, i, c, d_if[i][c], e_if[i][c]); end
          total++;
          if (d_ovf[i][c] !== e_ovf[i][c]) begin bad++; $display("FAIL rnd_ovf k=%0d u%0d ch%0d got=%b exp=%b", k, i, c, d_ovf[i][c], e_ovf[i][c]); end
          total++;
          if (d_smp[i][c] !== e_smp[i][c]) begin bad++; $display("FAIL rnd_sample k=%0d u%0d ch%0d got=%0d exp=%0d", k, i, c, d_smp[i][c], e_smp[i][c]); end
        end
        total++;
        if (d_ifv[i] !== e_ifv || d_ov[i] !== e_ov) begin bad++; $display("FAIL rnd_valids k=%0d u%0d got=%b%b exp=%b%b", k, i, d_ifv[i], d_ov[i], e_ifv, e_ov); end
      end
    end
    pd = '0;
  endtask
  initial begin
    rst_n = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
    test_reset;
    test_if_measure;
    test_boundary;
    test_saturation;
    test_pd_en;
    test_nco;
    test_random;
    test_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
